// File: rtl/usr_pkg.sv
// Shared types for the sequenced shift-register controller.
// Holds the command opcode enum, the FSM state enum and the mux-select codes
// that drive every bit slice.
package usr_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Slice select codes; the shift codes deliberately equal the shift opcodes.
  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

endpackage

// File: rtl/usr_bit_slice.sv
// One bit of the shift register: a 4:1 select over
// {hold, right-shift source, left-shift source, load bit} feeding one flop.
module usr_bit_slice
  import usr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sel,
  input  logic       shr_in,
  input  logic       shl_in,
  input  logic       load_in,
  output logic       q
);

  logic d;

  // Next-bit select: 00 hold, 01 right, 10 left, 11 load.
  always_comb begin
    d = q;
    case (sel)
      SEL_HOLD: d = q;
      SEL_SHR:  d = shr_in;
      SEL_SHL:  d = shl_in;
      SEL_LOAD: d = load_in;
      default:  d = q;
    endcase
  end

  // Bit storage, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

endmodule

// File: rtl/usr_seq_ctrl.sv
// Command-driven shift register: accepts nop / shift right / shift left /
// parallel load commands and sequences them through IDLE, LOAD, SHIFT, DONE.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
// cmd_ready is high only in IDLE, and cmd_valid in any other state is ignored.
// Optional macro USR_ROTATE_EN adds cmd_rot: when set, shifts recirculate the
// outgoing bit instead of taking the serial inputs.
// state_dbg and rem_dbg expose the FSM state and remaining-step counter.
module usr_seq_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
`ifdef USR_ROTATE_EN
  input  logic             cmd_rot,
`endif
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg,
  output logic [CNT_W-1:0] rem_dbg
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_LOAD  = ST_LOAD;
  localparam logic [1:0] S_SHIFT = ST_SHIFT;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] rem;
  logic [WIDTH-1:0] data_q;
  logic             ser_r;
  logic             ser_l;
  logic [WIDTH-1:0] shr_vec;
  logic [WIDTH-1:0] shl_vec;

`ifdef USR_ROTATE_EN
  logic rot_q;

  // Rotation latch, captured together with the rest of the command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       rot_q <= 1'b0;
    else if (state == S_IDLE && cmd_valid) rot_q <= cmd_rot;
  end

  assign ser_r = rot_q ? q[0]       : ser_in_r;
  assign ser_l = rot_q ? q[WIDTH-1] : ser_in_l;
`else
  assign ser_r = ser_in_r;
  assign ser_l = ser_in_l;
`endif

  // FSM, command latch and remaining-step counter. The counter exits SHIFT on
  // remaining==1, so the full 2^CNT_W-1 count runs without wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= OP_NOP;
      rem    <= '0;
      data_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            rem    <= cmd_cnt;
            data_q <= cmd_data;
            if (cmd_op == OP_LOAD)
              state <= S_LOAD;
            else if (cmd_op != OP_NOP && cmd_cnt != '0)
              state <= S_SHIFT;
            else
              state <= S_DONE;
          end
        end
        S_LOAD:  state <= S_DONE;
        S_SHIFT: begin
          rem <= rem - 1'b1;
          if (rem == CNT_W'(1)) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Slice select: only LOAD and SHIFT move data; the latched shift opcode
  // doubles as the shift select code.
  always_comb begin
    sel = SEL_HOLD;
    case (state)
      S_LOAD:  sel = SEL_LOAD;
      S_SHIFT: sel = op_q;
      default: sel = SEL_HOLD;
    endcase
  end

  assign shr_vec = {ser_r, q[WIDTH-1:1]};
  assign shl_vec = {q[WIDTH-2:0], ser_l};

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    usr_bit_slice u_slice (
      .clk     (clk),
      .rst_n   (rst_n),
      .sel     (sel),
      .shr_in  (shr_vec[i]),
      .shl_in  (shl_vec[i]),
      .load_in (data_q[i]),
      .q       (q[i])
    );
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign state_dbg = state;
  assign rem_dbg   = rem;

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Self-checking bench for usr_seq_ctrl (WIDTH=4, CNT_W=4). Inputs are driven
// and outputs sampled on the falling clock edge.
module tb_usr_seq_ctrl;

  localparam int W  = 4;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_cnt;
  logic [W-1:0]  cmd_data;
  logic          ser_in_r;
  logic          ser_in_l;
`ifdef USR_ROTATE_EN
  logic          cmd_rot;
`endif
  logic [1:0]    sel;
  logic [W-1:0]  q;
  logic          busy;
  logic          done;
  logic [1:0]    state_dbg;
  logic [CW-1:0] rem_dbg;

  int vectors;
  int miscompares;
  logic [W-1:0] exp_q[$];

  usr_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .cmd_data  (cmd_data),
    .ser_in_r  (ser_in_r),
    .ser_in_l  (ser_in_l),
`ifdef USR_ROTATE_EN
    .cmd_rot   (cmd_rot),
`endif
    .sel       (sel),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg),
    .rem_dbg   (rem_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic logic [W-1:0] shift_model(input logic [W-1:0] v, input logic [1:0] dir,
                                               input logic sr, input logic sl);
    if (dir == 2'b01) return {sr, v[W-1:1]};
    else              return {v[W-2:0], sl};
  endfunction

  // ---------------- drivers ----------------
  // Offer a command for one cycle; returns at the falling edge of the first
  // cycle after the acceptance edge.
  task automatic issue(input logic [1:0] op, input logic [CW-1:0] cnt, input logic [W-1:0] data);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Load a value and wait (bounded) for completion; returns in IDLE.
  task automatic do_load(input logic [W-1:0] data, output logic ok);
    ok = 1'b0;
    issue(2'b11, '0, data);
    for (int k = 0; k < 8; k++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = 2'b11;
    cmd_cnt = 4'd3;
    cmd_data = 4'b1111;
    repeat (3) @(negedge clk);
    vectors++; if (q !== 4'b0000) begin miscompares++; $display("FAIL rst_q: got %b expected 0000", q); end
    vectors++; if (sel !== 2'b00) begin miscompares++; $display("FAIL rst_sel: got %b expected 00", sel); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b expected 0", done); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b expected 1", cmd_ready); end
    vectors++; if (state_dbg !== 2'b00) begin miscompares++; $display("FAIL rst_state: got %b expected 00", state_dbg); end
    vectors++; if (rem_dbg !== 4'd0) begin miscompares++; $display("FAIL rst_rem: got %0d expected 0", rem_dbg); end
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (state_dbg !== 2'b00) begin miscompares++; $display("FAIL rst_no_accept: got state %b expected 00", state_dbg); end
  endtask

  task automatic test_load;
    issue(2'b11, '0, 4'b1010);
    exp_q.push_back(4'b1010);
    vectors++; if (sel !== 2'b11) begin miscompares++; $display("FAIL load_sel: got %b expected 11", sel); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL load_busy: got %b expected 1", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL load_early_done: got %b expected 0", done); end
    vectors++; if (q !== 4'b0000) begin miscompares++; $display("FAIL load_q_c1: got %b expected 0000", q); end
    @(negedge clk);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL load_done: got %b expected 1", done); end
    vectors++; if (sel !== 2'b00) begin miscompares++; $display("FAIL load_done_sel: got %b expected 00", sel); end
    begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      vectors++; if (q !== e) begin miscompares++; $display("FAIL load_q: got %b expected %b", q, e); end
    end
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin miscompares++; $display("FAIL load_idle: got busy %b ready %b expected 0 1", busy, cmd_ready); end
  endtask

  task automatic test_shift_right;
    ser_in_r = 1'b1;
    issue(2'b01, 4'd2, 4'b0000);
    exp_q.push_back(4'b1010);
    exp_q.push_back(4'b1101);
    exp_q.push_back(4'b1110);
    for (int c = 1; c <= 3; c++) begin
      logic [W-1:0] e;
      logic [1:0] es;
      e = exp_q.pop_front();
      es = (c < 3) ? 2'b01 : 2'b00;
      vectors++; if (q !== e) begin miscompares++; $display("FAIL shr_q cycle %0d: got %b expected %b", c, q, e); end
      vectors++; if (sel !== es) begin miscompares++; $display("FAIL shr_sel cycle %0d: got %b expected %b", c, sel, es); end
      vectors++; if (done !== (c == 3)) begin miscompares++; $display("FAIL shr_done cycle %0d: got %b expected %b", c, done, c == 3); end
      @(negedge clk);
    end
    ser_in_r = 1'b0;
  endtask

  task automatic test_shift_left;
    logic ok;
    do_load(4'b1010, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL shl_preload: got %b expected 1", ok); end
    ser_in_l = 1'b0;
    issue(2'b10, 4'd3, 4'b1111);
    exp_q.push_back(4'b1010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0000);
    for (int c = 1; c <= 4; c++) begin
      logic [W-1:0] e;
      logic [1:0] es;
      e = exp_q.pop_front();
      es = (c < 4) ? 2'b10 : 2'b00;
      vectors++; if (q !== e) begin miscompares++; $display("FAIL shl_q cycle %0d: got %b expected %b", c, q, e); end
      vectors++; if (sel !== es) begin miscompares++; $display("FAIL shl_sel cycle %0d: got %b expected %b", c, sel, es); end
      vectors++; if (done !== (c == 4)) begin miscompares++; $display("FAIL shl_done cycle %0d: got %b expected %b", c, done, c == 4); end
      @(negedge clk);
    end
  endtask

  task automatic test_nop_cnt0;
    logic ok;
    do_load(4'b0110, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL nop_preload: got %b expected 1", ok); end
    for (int t = 0; t < 2; t++) begin
      issue((t == 0) ? 2'b00 : 2'b01, (t == 0) ? 4'd5 : 4'd0, 4'b1111);
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL nop_done case %0d: got %b expected 1", t, done); end
      vectors++; if (sel !== 2'b00) begin miscompares++; $display("FAIL nop_sel case %0d: got %b expected 00", t, sel); end
      vectors++; if (q !== 4'b0110) begin miscompares++; $display("FAIL nop_q case %0d: got %b expected 0110", t, q); end
      @(negedge clk);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL nop_idle case %0d: got busy %b expected 0", t, busy); end
    end
  endtask

  // Random shifts with serial inputs changing every cycle and junk offered on
  // the command port while busy.
  task automatic test_random_shift;
    for (int t = 0; t < 6; t++) begin
      logic ok;
      logic [W-1:0] model;
      logic [1:0] dir;
      int n;
      model = W'($urandom_range(0, 15));
      do_load(model, ok);
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rnd_preload %0d: got %b expected 1", t, ok); end
      dir = 2'($urandom_range(1, 2));
      n = $urandom_range(1, 6);
      issue(dir, CW'(n), 4'b0000);
      for (int c = 1; c <= n; c++) begin
        logic [W-1:0] e;
        ser_in_r  = 1'($urandom_range(0, 1));
        ser_in_l  = 1'($urandom_range(0, 1));
        cmd_valid = 1'b1;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_cnt   = CW'($urandom_range(0, 15));
        cmd_data  = W'($urandom_range(0, 15));
        model = shift_model(model, dir, ser_in_r, ser_in_l);
        exp_q.push_back(model);
        vectors++; if (sel !== dir) begin miscompares++; $display("FAIL rnd_sel %0d/%0d: got %b expected %b", t, c, sel, dir); end
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++; if (q !== e) begin miscompares++; $display("FAIL rnd_q %0d/%0d: got %b expected %b", t, c, q, e); end
      end
      cmd_valid = 1'b0;
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL rnd_done %0d: got %b expected 1", t, done); end
      @(negedge clk);
      vectors++; if (cmd_ready !== 1'b1 || q !== model) begin miscompares++; $display("FAIL rnd_idle %0d: got ready %b q %b expected 1 %b", t, cmd_ready, q, model); end
    end
  endtask

  task automatic test_reset_abort;
    logic ok;
    logic saw_done;
    ser_in_r = 1'b1;
    issue(2'b01, 4'd15, 4'b0000);
    repeat (4) @(negedge clk);
    vectors++; if (state_dbg !== 2'b10) begin miscompares++; $display("FAIL abort_in_shift: got state %b expected 10", state_dbg); end
    rst_n = 1'b0;
    #1;
    vectors++; if (q !== 4'b0000) begin miscompares++; $display("FAIL abort_q: got %b expected 0000", q); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0 || sel !== 2'b00) begin miscompares++; $display("FAIL abort_outs: got busy %b done %b sel %b expected 0 0 00", busy, done, sel); end
    vectors++; if (state_dbg !== 2'b00 || rem_dbg !== 4'd0) begin miscompares++; $display("FAIL abort_state: got state %b rem %0d expected 00 0", state_dbg, rem_dbg); end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    vectors++; if (saw_done !== 1'b0) begin miscompares++; $display("FAIL abort_no_done: got activity %b expected 0", saw_done); end
    ser_in_r = 1'b0;
    do_load(4'b0011, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL abort_reload_done: got %b expected 1", ok); end
    vectors++; if (q !== 4'b0011) begin miscompares++; $display("FAIL abort_reload_q: got %b expected 0011", q); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] e;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_cnt   = 4'd0;
    cmd_data  = 4'b1001;
    ser_in_r  = 1'b0;
`ifdef USR_ROTATE_EN
    cmd_rot   = 1'b0;
`endif
    exp_q.push_back(4'b1001);
`ifdef USR_ROTATE_EN
    exp_q.push_back(4'b1100);
`else
    exp_q.push_back(4'b0100);
`endif
    @(negedge clk);
    vectors++; if (state_dbg !== 2'b01 || cmd_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_load: got state %b ready %b expected 01 0", state_dbg, cmd_ready); end
    cmd_op   = 2'b01;
    cmd_cnt  = 4'd1;
    cmd_data = 4'b0000;
`ifdef USR_ROTATE_EN
    cmd_rot  = 1'b1;
`endif
    @(negedge clk);
    e = exp_q.pop_front();
    vectors++; if (done !== 1'b1 || q !== e) begin miscompares++; $display("FAIL b2b_load_done: got done %b q %b expected 1 %b", done, q, e); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_in_done: got %b expected 0", cmd_ready); end
    @(negedge clk);
    vectors++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: got ready %b busy %b expected 1 0", cmd_ready, busy); end
    @(negedge clk);
    cmd_valid = 1'b0;
    vectors++; if (state_dbg !== 2'b10 || sel !== 2'b01) begin miscompares++; $display("FAIL b2b_shift: got state %b sel %b expected 10 01", state_dbg, sel); end
    @(negedge clk);
    e = exp_q.pop_front();
    vectors++; if (done !== 1'b1 || q !== e) begin miscompares++; $display("FAIL b2b_shift_done: got done %b q %b expected 1 %b", done, q, e); end
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_cnt = '0;
    cmd_data = '0;
    ser_in_r = 1'b0;
    ser_in_l = 1'b0;
`ifdef USR_ROTATE_EN
    cmd_rot = 1'b0;
`endif
    test_reset();
    test_load();
    test_shift_right();
    test_shift_left();
    test_nop_cnt0();
    test_random_shift();
    test_reset_abort();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/usr_seq_ctrl.md
USR_SEQ_CTRL -- requirements
Module: usr_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: shift register width in bits, minimum 2.
REQ-002 Parameter CNT_W, default 4: width of the shift-count field.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command can be accepted.
- cmd_op  in  2  00 nop, 01 shift right, 10 shift left, 11 parallel load.
- cmd_cnt  in  CNT_W  number of shift steps.
- cmd_data  in  WIDTH  parallel load value.
- ser_in_r  in  1  serial input for right shift, enters the MSB.
- ser_in_l  in  1  serial input for left shift, enters the LSB.
- sel  out  2  mux select driven to every bit slice (00 hold, 01 right, 10 left, 11 load).
- q  out  WIDTH  register contents.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.

Function
REQ-004 The state machine SHALL have four states: IDLE, LOAD, SHIFT and DONE.
REQ-005 A command SHALL be accepted on a rising edge where cmd_valid && cmd_ready; cmd_ready SHALL be 1 only in IDLE.
REQ-006 On acceptance the block SHALL latch op, cnt and data, and SHALL transition as follows:
- op=11: go to LOAD.
- op=01 or 10 with cnt!=0: go to SHIFT.
- op=00, or cnt==0: go to DONE.
REQ-007 LOAD SHALL drive sel=11, capture the latched data into q on the next edge, and then go to DONE.
REQ-008 SHIFT SHALL drive sel=01 or 10 for exactly cnt cycles and shift q once per edge, then go to DONE.
- Right shift: q <= {ser_in_r, q[WIDTH-1:1]}.
- Left shift: q <= {q[WIDTH-2:0], ser_in_l}.
REQ-009 The remaining-step counter SHALL load cnt and decrement each SHIFT edge; SHIFT SHALL exit on the edge where remaining==1. cnt = 2^CNT_W-1 SHALL be fully supported with no wrap.
REQ-010 DONE SHALL last one cycle with done=1 and sel=00, then return to IDLE.
REQ-011 In IDLE and DONE, sel SHALL be 00 and q SHALL hold.
REQ-012 busy SHALL be 1 in LOAD, SHIFT and DONE, and 0 in IDLE.
REQ-013 Latency from the acceptance edge to the done cycle SHALL be:
- load: 2 cycles;
- shift n: n+1 cycles;
- nop or cnt=0: 1 cycle.
REQ-014 cmd_valid asserted outside IDLE SHALL be ignored; the command input fields SHALL NOT affect an operation in progress.
REQ-015 Serial inputs SHALL be sampled at each SHIFT edge, not latched at acceptance.

Reset
REQ-016 While rst_n=0 the outputs SHALL be: state=IDLE, q=0, sel=00, busy=0, done=0, cmd_ready=1, remaining counter=0.
REQ-017 No command SHALL be accepted while rst_n=0.
REQ-018 Reset asserted during LOAD or SHIFT SHALL abort the command immediately with no done pulse; normal operation SHALL resume on the first edge after release.

Configuration
REQ-019 Macro USR_ROTATE_EN:
- Defined: an input port cmd_rot (1 bit) SHALL be added and latched at acceptance. When cmd_rot=1, right shift SHALL feed q[0] into the MSB, left shift SHALL feed q[WIDTH-1] into the LSB, and the serial inputs SHALL be ignored.
- Undefined: the cmd_rot port SHALL be absent and shifts SHALL always use ser_in_r/ser_in_l.

Structure
REQ-020 Package usr_pkg SHALL hold the op enum (OP_NOP, OP_SHR, OP_SHL, OP_LOAD) and the state enum.
REQ-021 Sub-module usr_bit_slice SHALL contain one 4:1 select over {hold, right neighbour, left neighbour, load bit} plus one flop.
- It SHALL be instanced WIDTH times.
- The FSM and counter SHALL live in usr_seq_ctrl.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Load 4'b1010 -> sel=11 for one cycle; q=1010 and done=1 two cycles after acceptance.
- After load 1010, shift right cnt=2 with ser_in_r=1 -> q=1101, then 1110; done at acceptance+3.
- After load 1010, shift left cnt=3 with ser_in_l=0 -> q=0100, 1000, 0000.
- nop, then shift with cnt=0 -> each gives done one cycle after acceptance, q unchanged, sel stays 00.
- Shift cnt=15, with rst_n pulsed low at step 5 -> q=0 and no done pulse; a new load 0011 after release is accepted and completes normally.
- USR_ROTATE_EN defined, load 1001, rotate right cnt=1 -> q=1100; cmd_valid held high throughout -> the next command is accepted only after DONE.
